// File: rtl/ctrl_ajuste_relogio.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_ajuste_relogio
//  Description : Time-setting controller for the digital clock. Conditions
//                the mode/increment push-buttons, sequences RUN -> SET_HOUR
//                -> SET_MIN -> RUN, gates the 1 Hz enable, issues hour and
//                minute increment pulses, clears seconds when leaving a set
//                state and blinks the digit pair being adjusted.
//                Optional macro AUTO_REPEAT_EN adds auto-repeat of the
//                increment button while it is held.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_ajuste_relogio #(
  parameter int DEBOUNCE_CYCLES      = 500000,
  parameter int TIMEOUT_S            = 30
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY_CYCLES  = 25000000,
  parameter int REPEAT_PERIOD_CYCLES = 5000000
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode_n,
  input  logic       btn_inc_n,
  output logic       enable_out,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       clr_sec,
  output logic       blank_hour,
  output logic       blank_min,
  output logic [1:0] mode_out
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  // Timeout counter only needs to reach TIMEOUT_S-1; the next tick fires.
  localparam int TO_W = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_S - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } state_t;

  // Bit 0 is the mode button, bit 1 the increment button (both active-low).
  logic [1:0]           sync1;
  logic [1:0]           sync2;
  logic [1:0]           db_n;
  logic [1:0][DB_W-1:0] db_cnt;
  logic [1:0]           accept;
  logic                 mode_press;
  logic                 inc_press;
  logic                 rep_fire;
  logic                 inc_evt;
  logic                 in_set;
  logic                 timeout_hit;

  state_t               state;
  state_t               next_state;
  logic                 state_change;
  logic [TO_W-1:0]      tmo_cnt;
  logic [TO_W-1:0]      tmo_next;
  logic                 phase;
  logic                 phase_next;
  logic                 inc_hour_next;
  logic                 inc_min_next;
  logic                 clr_sec_next;

  // Synchronize both buttons and accept a level only after it has been stable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      db_n   <= 2'b11;
      db_cnt <= '0;
    end else begin
      sync1 <= {btn_inc_n, btn_mode_n};
      sync2 <= sync1;
      for (int b = 0; b < 2; b++) begin
        if (sync2[b] != db_n[b]) begin
          if (db_cnt[b] == DB_LAST) begin
            db_n[b]   <= sync2[b];
            db_cnt[b] <= '0;
          end else begin
            db_cnt[b] <= db_cnt[b] + 1'b1;
          end
        end else begin
          db_cnt[b] <= '0;
        end
      end
    end
  end

  // A press is the cycle in which the debounced level is about to go low.
  assign accept     = (sync2 ^ db_n) & {(db_cnt[1] == DB_LAST), (db_cnt[0] == DB_LAST)};
  assign mode_press = accept[0] & ~sync2[0];
  assign inc_press  = accept[1] & ~sync2[1];

  assign in_set      = (state != ST_RUN);
  assign inc_evt     = inc_press | rep_fire;
  // An inc event on the tick clears the count, so that tick can never time out.
  assign timeout_hit = in_set && tick_1hz && !inc_evt && (tmo_cnt == TO_LAST);

`ifdef AUTO_REPEAT_EN
  localparam int RP_W = (REPEAT_DELAY_CYCLES > 1) ? $clog2(REPEAT_DELAY_CYCLES) : 1;
  localparam logic [RP_W-1:0] RP_LAST   = RP_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_RELOAD = RP_W'(REPEAT_DELAY_CYCLES - REPEAT_PERIOD_CYCLES);

  logic [RP_W-1:0] rep_cnt;

  assign rep_fire = !db_n[1] && in_set && (rep_cnt == RP_LAST);

  // Hold timer: first repeat after the delay, then reload so the period follows.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rep_cnt <= '0;
    end else if (db_n[1] || !in_set || state_change) begin
      rep_cnt <= '0;
    end else if (rep_fire) begin
      rep_cnt <= RP_RELOAD;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Next state, timeout count, blink phase and pulse requests.
  always_comb begin
    next_state    = state;
    tmo_next      = tmo_cnt;
    phase_next    = phase;
    if (timeout_hit) begin
      next_state = ST_RUN;
    end else if (mode_press) begin
      case (state)
        ST_RUN:      next_state = ST_SET_HOUR;
        ST_SET_HOUR: next_state = ST_SET_MIN;
        default:     next_state = ST_RUN;
      endcase
    end
    state_change = (next_state != state);

    if (state_change || mode_press || inc_evt) begin
      tmo_next = '0;
    end else if (in_set && tick_1hz) begin
      tmo_next = tmo_cnt + 1'b1;
    end

    // Keep the adjusted digit visible right after entry or an increment.
    if (state_change || (in_set && inc_evt)) begin
      phase_next = 1'b0;
    end else if (in_set && tick_1hz) begin
      phase_next = ~phase;
    end

    // Mode wins over a simultaneous inc event.
    inc_hour_next = (state == ST_SET_HOUR) && inc_evt && !mode_press;
    inc_min_next  = (state == ST_SET_MIN) && inc_evt && !mode_press;
    clr_sec_next  = in_set && (next_state == ST_RUN);
  end

  // State and registered pulse outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_RUN;
      tmo_cnt  <= '0;
      phase    <= 1'b0;
      inc_hour <= 1'b0;
      inc_min  <= 1'b0;
      clr_sec  <= 1'b0;
    end else begin
      state    <= next_state;
      tmo_cnt  <= tmo_next;
      phase    <= phase_next;
      inc_hour <= inc_hour_next;
      inc_min  <= inc_min_next;
      clr_sec  <= clr_sec_next;
    end
  end

  assign enable_out = tick_1hz && (state == ST_RUN);
  assign blank_hour = (state == ST_SET_HOUR) && phase;
  assign blank_min  = (state == ST_SET_MIN) && phase;
  assign mode_out   = state;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_ajuste_relogio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_ajuste_relogio
//  Description : Self-checking bench for ctrl_ajuste_relogio with a
//                behavioural reference model (raw-sample windows for
//                debounce, rule-based mode/blink/timeout/repeat tracking).
//                Honours the AUTO_REPEAT_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_ajuste_relogio;

  localparam int DB = 4;
  localparam int TO = 3;
  localparam int RD = 20;
  localparam int RP = 5;
`ifdef AUTO_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic       btn_mode_n;
  logic       btn_inc_n;
  logic       enable_out;
  logic       inc_hour;
  logic       inc_min;
  logic       clr_sec;
  logic       blank_hour;
  logic       blank_min;
  logic [1:0] mode_out;

  int errors = 0;
  int checks = 0;

  ctrl_ajuste_relogio #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_S(TO)
`ifdef AUTO_REPEAT_EN
    , .REPEAT_DELAY_CYCLES(RD),
    .REPEAT_PERIOD_CYCLES(RP)
`endif
  ) dut (
    .clock(clock),
    .reset(reset),
    .tick_1hz(tick_1hz),
    .btn_mode_n(btn_mode_n),
    .btn_inc_n(btn_inc_n),
    .enable_out(enable_out),
    .inc_hour(inc_hour),
    .inc_min(inc_min),
    .clr_sec(clr_sec),
    .blank_hour(blank_hour),
    .blank_min(blank_min),
    .mode_out(mode_out)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  bit mq[$];
  bit iq[$];
  bit m_acc, i_acc;
  int m_mode, m_tcnt, m_hold;
  bit m_phase, e_ih, e_im, e_clr;
  int n_ih = 0, n_im = 0, n_clr = 0;

  // observed pulse counts and mode changes
  int o_ih = 0, o_im = 0, o_clr = 0, o_mchg = 0;
  logic [1:0] prev_mode = 2'd0;

  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (inc_hour === 1'b1) o_ih++;
      if (inc_min === 1'b1) o_im++;
      if (clr_sec === 1'b1) o_clr++;
      if (mode_out !== prev_mode) o_mchg++;
    end
    prev_mode = mode_out;
  end

  function automatic void model_reset();
    mq.delete();
    iq.delete();
    for (int i = 0; i < DB + 2; i++) begin
      mq.push_back(1'b0);
      iq.push_back(1'b0);
    end
    m_acc = 0; i_acc = 0;
    m_mode = 0; m_tcnt = 0; m_hold = 0;
    m_phase = 0; e_ih = 0; e_im = 0; e_clr = 0;
  endfunction

  // True when the DB oldest synchronized samples all disagree with acc.
  function automatic bit window_flips(bit acc, bit which_inc);
    for (int i = 0; i < DB; i++) begin
      if ((which_inc ? iq[i] : mq[i]) == acc) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_edge();
    bit mp, ip, fire, inc_evt, in_set, tout, old_i;
    int new_mode;
    mq.push_back(!btn_mode_n);
    iq.push_back(!btn_inc_n);
    while (mq.size() > DB + 2) void'(mq.pop_front());
    while (iq.size() > DB + 2) void'(iq.pop_front());
    mp = 0; ip = 0; old_i = i_acc;
    if (window_flips(m_acc, 1'b0)) begin m_acc = !m_acc; mp = m_acc; end
    if (window_flips(i_acc, 1'b1)) begin i_acc = !i_acc; ip = i_acc; end
    in_set = (m_mode != 0);
    fire = 0;
    if (REPEAT_ON && old_i && in_set) begin
      m_hold++;
      if (m_hold == RD || (m_hold > RD && (m_hold - RD) % RP == 0)) fire = 1;
    end
    inc_evt = ip || fire;
    tout = in_set && tick_1hz && !inc_evt && (m_tcnt + 1 == TO);
    new_mode = m_mode;
    if (tout) new_mode = 0;
    else if (mp) new_mode = (m_mode + 1) % 3;
    e_clr = in_set && (new_mode == 0);
    e_ih = (m_mode == 1) && inc_evt && !mp;
    e_im = (m_mode == 2) && inc_evt && !mp;
    if (new_mode != m_mode || mp || inc_evt) m_tcnt = 0;
    else if (in_set && tick_1hz) m_tcnt++;
    if (new_mode != m_mode || (in_set && inc_evt)) m_phase = 0;
    else if (in_set && tick_1hz) m_phase = !m_phase;
    if (!old_i || !in_set || new_mode != m_mode) m_hold = 0;
    m_mode = new_mode;
    if (e_ih) n_ih++;
    if (e_im) n_im++;
    if (e_clr) n_clr++;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick_1hz = 1'b0;
    btn_mode_n = 1'b1;
    btn_inc_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic press(input bit which_inc);
    if (which_inc) btn_inc_n = 1'b0; else btn_mode_n = 1'b0;
    repeat (DB + 3) step();
    if (which_inc) btn_inc_n = 1'b1; else btn_mode_n = 1'b1;
    repeat (DB + 4) step();
    #1;
  endtask

  task automatic tick_step();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int b_ih;
    do_reset();
    press(1'b0);
    tick_step();
    checks++; if (blank_hour !== 1'b1) begin errors++; $display("FAIL rst_pre_blank: got %b want 1", blank_hour); end
    btn_inc_n = 1'b0;
    repeat (DB + 1) step();
    reset = 1'b0;
    model_reset();
    #1;
    checks++; if (mode_out !== 2'd0) begin errors++; $display("FAIL rst_mode: got %0d want 0", mode_out); end
    checks++; if (inc_hour !== 1'b0) begin errors++; $display("FAIL rst_inc_hour: got %b want 0", inc_hour); end
    checks++; if (inc_min !== 1'b0) begin errors++; $display("FAIL rst_inc_min: got %b want 0", inc_min); end
    checks++; if (clr_sec !== 1'b0) begin errors++; $display("FAIL rst_clr_sec: got %b want 0", clr_sec); end
    checks++; if (blank_hour !== 1'b0) begin errors++; $display("FAIL rst_blank_hour: got %b want 0", blank_hour); end
    checks++; if (blank_min !== 1'b0) begin errors++; $display("FAIL rst_blank_min: got %b want 0", blank_min); end
    tick_1hz = 1'b1; #1;
    checks++; if (enable_out !== 1'b1) begin errors++; $display("FAIL rst_enable_hi: got %b want 1", enable_out); end
    tick_1hz = 1'b0; #1;
    checks++; if (enable_out !== 1'b0) begin errors++; $display("FAIL rst_enable_lo: got %b want 0", enable_out); end
    btn_inc_n = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    b_ih = o_ih;
    repeat (DB + 4) step();
    #1;
    checks++; if (o_ih - b_ih !== 0) begin errors++; $display("FAIL rst_no_pulse: got %0d want 0", o_ih - b_ih); end
    checks++; if (mode_out !== 2'd0) begin errors++; $display("FAIL rst_mode_after: got %0d want 0", mode_out); end
  endtask

  task automatic test_debounce();
    int b_chg;
    do_reset();
    #1;
    b_chg = o_mchg;
    for (int g = 0; g < 3; g++) begin
      btn_mode_n = 1'b0; repeat (DB - 1) step();
      btn_mode_n = 1'b1; step();
    end
    #1;
    checks++; if (mode_out !== 2'd0) begin errors++; $display("FAIL db_glitch: got %0d want 0", mode_out); end
    btn_mode_n = 1'b0;
    repeat (DB + 8) step();
    for (int g = 0; g < 2; g++) begin
      btn_mode_n = 1'b1; repeat (DB - 2) step();
      btn_mode_n = 1'b0; step();
    end
    btn_mode_n = 1'b1;
    repeat (DB + 6) step();
    #1;
    checks++; if (mode_out !== 2'd1) begin errors++; $display("FAIL db_mode: got %0d want 1", mode_out); end
    checks++; if (o_mchg - b_chg !== 1) begin errors++; $display("FAIL db_transitions: got %0d want 1", o_mchg - b_chg); end
    for (int t = 0; t < 2; t++) begin
      tick_1hz = 1'b1; #1;
      checks++; if (enable_out !== 1'b0) begin errors++; $display("FAIL db_enable_frozen: got %b want 0", enable_out); end
      step();
      tick_1hz = 1'b0;
      repeat (3) step();
    end
  endtask

  task automatic test_sequence();
    int b_ih, b_im, b_clr;
    do_reset();
    #1;
    b_ih = o_ih; b_im = o_im; b_clr = o_clr;
    press(1'b0);
    checks++; if (mode_out !== 2'd1) begin errors++; $display("FAIL seq_mode1: got %0d want 1", mode_out); end
    press(1'b1);
    press(1'b1);
    press(1'b0);
    checks++; if (mode_out !== 2'd2) begin errors++; $display("FAIL seq_mode2: got %0d want 2", mode_out); end
    press(1'b1);
    press(1'b0);
    checks++; if (mode_out !== 2'd0) begin errors++; $display("FAIL seq_mode0: got %0d want 0", mode_out); end
    checks++; if (o_ih - b_ih !== 2) begin errors++; $display("FAIL seq_inc_hour: got %0d want 2", o_ih - b_ih); end
    checks++; if (o_im - b_im !== 1) begin errors++; $display("FAIL seq_inc_min: got %0d want 1", o_im - b_im); end
    checks++; if (o_clr - b_clr !== 1) begin errors++; $display("FAIL seq_clr_sec: got %0d want 1", o_clr - b_clr); end
  endtask

  task automatic test_timeout();
    do_reset();
    press(1'b0);
    press(1'b0);
    checks++; if (mode_out !== 2'd2) begin errors++; $display("FAIL to_enter: got %0d want 2", mode_out); end
    tick_step();
    tick_step();
    checks++; if (mode_out !== 2'd2) begin errors++; $display("FAIL to_hold: got %0d want 2", mode_out); end
    tick_step();
    checks++; if (mode_out !== 2'd0) begin errors++; $display("FAIL to_return: got %0d want 0", mode_out); end
    checks++; if (clr_sec !== 1'b1) begin errors++; $display("FAIL to_clr_sec: got %b want 1", clr_sec); end
    press(1'b0);
    press(1'b0);
    tick_step();
    tick_step();
    press(1'b1);
    tick_step();
    tick_step();
    checks++; if (mode_out !== 2'd2) begin errors++; $display("FAIL to_restart_hold: got %0d want 2", mode_out); end
    tick_step();
    checks++; if (mode_out !== 2'd0) begin errors++; $display("FAIL to_restart_return: got %0d want 0", mode_out); end
    checks++; if (clr_sec !== 1'b1) begin errors++; $display("FAIL to_restart_clr: got %b want 1", clr_sec); end
  endtask

  task automatic test_blink();
    int b_ih, b_im;
    do_reset();
    press(1'b0);
    checks++; if (blank_hour !== 1'b0) begin errors++; $display("FAIL blink_entry: got %b want 0", blank_hour); end
    tick_step();
    checks++; if (blank_hour !== 1'b1) begin errors++; $display("FAIL blink_t1: got %b want 1", blank_hour); end
    tick_step();
    checks++; if (blank_hour !== 1'b0) begin errors++; $display("FAIL blink_t2: got %b want 0", blank_hour); end
    press(1'b1);
    btn_inc_n = 1'b0;
    repeat (DB + 1) step();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    #1;
    checks++; if (blank_hour !== 1'b0) begin errors++; $display("FAIL blink_press_tick: got %b want 0", blank_hour); end
    checks++; if (inc_hour !== 1'b1) begin errors++; $display("FAIL blink_inc_hour: got %b want 1", inc_hour); end
    btn_inc_n = 1'b1;
    repeat (DB + 4) step();
    tick_step();
    checks++; if (blank_hour !== 1'b1) begin errors++; $display("FAIL blink_after: got %b want 1", blank_hour); end
    b_ih = o_ih; b_im = o_im;
    btn_mode_n = 1'b0; btn_inc_n = 1'b0;
    repeat (DB + 3) step();
    btn_mode_n = 1'b1; btn_inc_n = 1'b1;
    repeat (DB + 4) step();
    #1;
    checks++; if (mode_out !== 2'd2) begin errors++; $display("FAIL both_mode: got %0d want 2", mode_out); end
    checks++; if (o_ih - b_ih !== 0) begin errors++; $display("FAIL both_inc_hour: got %0d want 0", o_ih - b_ih); end
    checks++; if (o_im - b_im !== 0) begin errors++; $display("FAIL both_inc_min: got %0d want 0", o_im - b_im); end
  endtask

  task automatic test_repeat();
    int b_im, nb_im, want;
    do_reset();
    press(1'b0);
    press(1'b0);
    b_im = o_im; nb_im = n_im;
    want = REPEAT_ON ? 6 : 1;
    btn_inc_n = 1'b0;
    repeat (40) step();
    btn_inc_n = 1'b1;
    repeat (DB + 6) step();
    #1;
    checks++; if (o_im - b_im !== want) begin errors++; $display("FAIL rep_count: got %0d want %0d", o_im - b_im, want); end
    checks++; if (o_im - b_im !== n_im - nb_im) begin errors++; $display("FAIL rep_model: got %0d want %0d", o_im - b_im, n_im - nb_im); end
  endtask

  task automatic test_random();
    bit mt, it;
    do_reset();
    mt = 0; it = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) mt = !mt;
      if ($urandom_range(0, 24) == 0) it = !it;
      btn_mode_n = ($urandom_range(0, 9) == 0) ? mt : !mt;
      btn_inc_n  = ($urandom_range(0, 9) == 0) ? it : !it;
      tick_1hz   = ($urandom_range(0, 7) == 0);
      #1;
      checks++; if (enable_out !== (tick_1hz && m_mode == 0)) begin errors++; $display("FAIL rnd_enable c%0d: got %b want %b", c, enable_out, (tick_1hz && m_mode == 0)); end
      step();
      checks++; if (mode_out !== 2'(m_mode)) begin errors++; $display("FAIL rnd_mode c%0d: got %0d want %0d", c, mode_out, m_mode); end
      checks++; if (inc_hour !== e_ih) begin errors++; $display("FAIL rnd_inc_hour c%0d: got %b want %b", c, inc_hour, e_ih); end
      checks++; if (inc_min !== e_im) begin errors++; $display("FAIL rnd_inc_min c%0d: got %b want %b", c, inc_min, e_im); end
      checks++; if (clr_sec !== e_clr) begin errors++; $display("FAIL rnd_clr_sec c%0d: got %b want %b", c, clr_sec, e_clr); end
      checks++; if (blank_hour !== (m_mode == 1 && m_phase)) begin errors++; $display("FAIL rnd_blank_hour c%0d: got %b want %b", c, blank_hour, (m_mode == 1 && m_phase)); end
      checks++; if (blank_min !== (m_mode == 2 && m_phase)) begin errors++; $display("FAIL rnd_blank_min c%0d: got %b want %b", c, blank_min, (m_mode == 2 && m_phase)); end
    end
    tick_1hz = 1'b0;
    btn_mode_n = 1'b1;
    btn_inc_n = 1'b1;
    repeat (DB + 6) step();
    #1;
    checks++; if (o_ih !== n_ih) begin errors++; $display("FAIL rnd_total_inc_hour: got %0d want %0d", o_ih, n_ih); end
    checks++; if (o_im !== n_im) begin errors++; $display("FAIL rnd_total_inc_min: got %0d want %0d", o_im, n_im); end
    checks++; if (o_clr !== n_clr) begin errors++; $display("FAIL rnd_total_clr_sec: got %0d want %0d", o_clr, n_clr); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_sequence();
    test_timeout();
    test_blink();
    test_repeat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ctrl_ajuste_relogio.md
Name: ctrl_ajuste_relogio

Overview:
Time-setting controller for the digital clock. It takes two raw push-buttons and the 1 Hz enable pulse, and sequences the clock between normal counting and manual adjustment of hours and minutes. It gates the 1 Hz enable to the second/minute/hour state machines and issues increment pulses to them. It also drives blanking for the digit being adjusted.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable clock cycles required to accept a button level change (10 ms at 50 MHz)
TIMEOUT_S, 30, number of 1 Hz ticks without a button press in a set state before automatic return to RUN
REPEAT_DELAY_CYCLES, 25000000, hold time before the first auto-repeat (used only with AUTO_REPEAT_EN)
REPEAT_PERIOD_CYCLES, 5000000, interval between auto-repeat pulses (used only with AUTO_REPEAT_EN)

Ports:
clock  in  1  system clock; the only clock domain
reset  in  1  asynchronous, active-low reset
tick_1hz  in  1  one-cycle 1 Hz enable pulse from the clock divider
btn_mode_n  in  1  raw mode button, active-low, asynchronous
btn_inc_n  in  1  raw increment button, active-low, asynchronous
enable_out  out  1  gated 1 Hz enable to the seconds state machine
inc_hour  out  1  one-cycle hour increment pulse
inc_min  out  1  one-cycle minute increment pulse
clr_sec  out  1  one-cycle pulse that clears seconds to 00
blank_hour  out  1  blanks both hour displays while high
blank_min  out  1  blanks both minute displays while high
mode_out  out  2  current state: 0 RUN, 1 SET_HOUR, 2 SET_MIN

Behaviour:
- Reset (reset=0, asynchronous): state RUN; synchronizers and debounced levels = released; debounce, timeout and repeat counters = 0; blink phase = 0. All outputs 0 except enable_out, which follows its equation below.
- Input conditioning per button:
  - 2-flop synchronizer.
  - Debounce counter. The debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any mismatch gap restarts the count.
  - press = one-cycle pulse on the debounced released->pressed transition. Releases generate nothing.
  - Latency from a clean edge to press: 2 + DEBOUNCE_CYCLES cycles, ±1.
- FSM transitions on mode press: RUN->SET_HOUR->SET_MIN->RUN.
- enable_out = tick_1hz AND (state==RUN). Combinational, same cycle; counting is frozen in set states.
- Inc press:
  - SET_HOUR: inc_hour for 1 cycle, registered, asserted the cycle after the press.
  - SET_MIN: inc_min for 1 cycle, timed the same way.
  - RUN: ignored.
- Mode and inc press in the same cycle: mode wins; inc is dropped.
- clr_sec: 1-cycle pulse on every transition from a set state into RUN, whether by button or by timeout.
- Blink:
  - Phase toggles on each tick_1hz while in a set state.
  - Phase is forced to 0 on entry to any set state and on each inc press or repeat. A press in the same cycle as a tick takes priority, so the digit stays visible while adjusting.
  - blank_hour = (state==SET_HOUR) AND phase. blank_min = (state==SET_MIN) AND phase. Both are 0 in RUN.
- Timeout:
  - Counts tick_1hz while in a set state. Cleared on any press, any repeat, and any state change.
  - A press in the same cycle as a tick clears the counter; that tick is not counted.
  - When the count reaches TIMEOUT_S: go to RUN and pulse clr_sec.
  - A mode press in the same cycle as the timeout is treated as the timeout: one RUN entry, one clr_sec.
- Reset asserted mid-operation aborts any pending pulse; no inc_* or clr_sec pulse is emitted as a consequence.

Optional Feature:
AUTO_REPEAT_EN.
- Defined: while the inc button is held (debounced) in a set state, a repeat counter runs. It emits an extra inc pulse after REPEAT_DELAY_CYCLES, then every REPEAT_PERIOD_CYCLES. The counter resets on release or on any state change. Repeats behave exactly like presses for inc_*, blink and timeout.
- Undefined: exactly one inc pulse per press; the repeat logic and the REPEAT_* parameters are absent/unused.

Test Plan:
1. Reset low mid-count, then high → mode_out=0; inc_hour, inc_min, clr_sec, blank_* all 0; enable_out mirrors tick_1hz.
2. DEBOUNCE_CYCLES=4: mode button pressed with 3-cycle bounce glitches, then held → exactly one transition to mode_out=1. enable_out stays 0 on subsequent ticks.
3. From RUN: mode, inc, inc, mode, inc, mode → inc_hour pulses twice, inc_min once, mode_out sequence 1,2,0, one clr_sec on the final entry to RUN.
4. TIMEOUT_S=3: enter SET_MIN, apply 3 ticks with no presses → return to RUN on the 3rd tick with clr_sec=1. An inc press between ticks 2 and 3 restarts the count, so the return happens 3 ticks after that press.
5. SET_HOUR with ticks: blank_hour toggles 0,1,0 on successive ticks; an inc press coincident with a tick forces blank_hour=0; mode and inc pressed in the same cycle → mode_out=2, no inc_hour pulse.
6. AUTO_REPEAT_EN, REPEAT_DELAY_CYCLES=20, REPEAT_PERIOD_CYCLES=5, inc held for 40 cycles in SET_MIN → 1 press pulse + repeats at hold cycles 20, 25, 30, 35, 40; the macro undefined gives 1 pulse only.
